// File: rtl/sid_voice_mixer.sv
// Voice mixer: captures six time-multiplexed DCA samples, routes each to its chip's filter or
// direct sum, and publishes four registered sums with a one-clock strobe. Optional: SID_MIXER_MUTE_EN.
package sid;
   typedef logic [4:0]         cycle_t;
   typedef logic signed [21:0] s22_t;
endpackage

module sid_voice_mixer #(
   parameter int FIRST_SLOT = 8,
   parameter int OUT_BITS   = 24
) (
   input  logic                               clk,
   input  logic                               rst,
   input  sid::cycle_t                        cycle,
   input  sid::s22_t                          dca,
   input  logic [5:0]                         filt,
   input  logic [1:0]                         voice3off,
`ifdef SID_MIXER_MUTE_EN
   input  logic [5:0]                         mute,
`endif
   output logic signed [1:0][OUT_BITS-1:0]    filt_in,
   output logic signed [1:0][OUT_BITS-1:0]    direct,
   output logic                               mix_stb
);

   // mix_stb is a one-clock valid with no back-pressure: filt_in/direct are
   // stable from the strobe until the next strobe.
   logic [1:0][OUT_BITS-1:0] acc_filt_q, acc_filt_d;
   logic [1:0][OUT_BITS-1:0] acc_dir_q,  acc_dir_d;
   logic                     frame_q;

   int                       slot_int;
   logic                     active;
   logic [2:0]               slot;
   logic                     chip;
   logic [1:0]               vin;
   logic [OUT_BITS-1:0]      sample_ext;
   logic                     muted;
   logic                     to_filt;
   logic                     to_dir;
   logic                     first;
   logic                     publish;

   always_comb begin
      slot_int   = int'(cycle) - FIRST_SLOT;
      active     = (slot_int >= 0) && (slot_int <= 5);
      slot       = active ? slot_int[2:0] : 3'd0;
      chip       = (slot >= 3'd3);
      vin        = chip ? 2'(slot - 3'd3) : slot[1:0];
      sample_ext = {{(OUT_BITS-22){dca[21]}}, dca};
`ifdef SID_MIXER_MUTE_EN
      muted      = mute[slot];
`else
      muted      = 1'b0;
`endif
      to_filt    = filt[slot] && !muted;
      to_dir     = !filt[slot] && !((vin == 2'd2) && voice3off[chip]) && !muted;
      first      = (vin == 2'd0);
      publish    = active && (slot == 3'd5) && frame_q;

      acc_filt_d = acc_filt_q;
      acc_dir_d  = acc_dir_q;
      if (active) begin
         // The first voice of a chip loads rather than adds, so no clear cycle is needed.
         acc_filt_d[chip] = (first ? '0 : acc_filt_q[chip]) + (to_filt ? sample_ext : '0);
         acc_dir_d[chip]  = (first ? '0 : acc_dir_q[chip])  + (to_dir  ? sample_ext : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_filt_q <= '0;
         acc_dir_q  <= '0;
         frame_q    <= 1'b0;
         filt_in    <= '0;
         direct     <= '0;
         mix_stb    <= 1'b0;
      end else begin
         acc_filt_q <= acc_filt_d;
         acc_dir_q  <= acc_dir_d;
         mix_stb    <= publish;
         if (active && (slot == 3'd0)) begin
            frame_q <= 1'b1;
         end else if (publish) begin
            frame_q <= 1'b0;
         end
         if (publish) begin
            filt_in <= acc_filt_d;
            direct  <= acc_dir_d;
         end
      end
   end

endmodule

// File: tb/tb_sid_voice_mixer.sv
// Scoreboard bench for sid_voice_mixer: directed frames push expected sums, a monitor checks each strobe.
module tb_sid_voice_mixer;

   localparam int FIRST_SLOT = 8;
   localparam int OUT_BITS   = 24;
   localparam int PERIOD     = 16;

   logic                            clk;
   logic                            rst;
   sid::cycle_t                     cycle;
   sid::s22_t                       dca;
   logic [5:0]                      filt;
   logic [1:0]                      voice3off;
`ifdef SID_MIXER_MUTE_EN
   logic [5:0]                      mute;
`endif
   logic signed [1:0][OUT_BITS-1:0] filt_in;
   logic signed [1:0][OUT_BITS-1:0] direct;
   logic                            mix_stb;

   logic [OUT_BITS-1:0] exp_q[$];
   int                  checks;
   int                  failures;
   int                  smp[6];

   sid_voice_mixer #(.FIRST_SLOT(FIRST_SLOT), .OUT_BITS(OUT_BITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .cycle     (cycle),
      .dca       (dca),
      .filt      (filt),
      .voice3off (voice3off),
`ifdef SID_MIXER_MUTE_EN
      .mute      (mute),
`endif
      .filt_in   (filt_in),
      .direct    (direct),
      .mix_stb   (mix_stb)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [OUT_BITS-1:0] got, input logic [OUT_BITS-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d required %0d", name, $signed(got), $signed(exp));
      end
   endtask

   // driver: one full sample period; slot inputs use fa for chip 0 slots and fb for chip 1 slots
   task automatic run_frame(input logic [5:0] fa, input logic [5:0] fb, input logic [1:0] v3,
                            input logic [5:0] mu, input int rst_at, input logic exp_pub,
                            input int ef0, input int ed0, input int ef1, input int ed1);
      int s;
      if (exp_pub) begin
         exp_q.push_back(OUT_BITS'(ef0));
         exp_q.push_back(OUT_BITS'(ed0));
         exp_q.push_back(OUT_BITS'(ef1));
         exp_q.push_back(OUT_BITS'(ed1));
      end
      for (int c = 0; c < PERIOD; c++) begin
         @(posedge clk);
         #1;
         cycle = sid::cycle_t'(c);
         rst   = (c == rst_at);
         s     = c - FIRST_SLOT;
         if (s >= 0 && s <= 5) begin
            dca       = sid::s22_t'(smp[s]);
            filt      = (s < 3) ? fa : fb;
            voice3off = v3;
`ifdef SID_MIXER_MUTE_EN
            mute      = mu;
`endif
         end else begin
            dca       = sid::s22_t'($urandom);
            filt      = 6'($urandom);
            voice3off = 2'($urandom);
`ifdef SID_MIXER_MUTE_EN
            mute      = 6'($urandom);
`endif
         end
      end
      if (mu != 6'd0) begin
         // mute only matters when the feature is compiled in
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (mix_stb) begin
         checks++;
         if (exp_q.size() < 4) begin
            failures++;
            $display("FAIL unexpected_stb: got strobe at cycle %0d required no strobe", cycle);
         end else begin
            check("filt_in0", filt_in[0], exp_q.pop_front());
            check("direct0",  direct[0],  exp_q.pop_front());
            check("filt_in1", filt_in[1], exp_q.pop_front());
            check("direct1",  direct[1],  exp_q.pop_front());
            check("stb_cycle", OUT_BITS'(cycle), OUT_BITS'(FIRST_SLOT + 6));
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_filt_in0"}, filt_in[0], '0);
      check({tag, "_direct0"},  direct[0],  '0);
      check({tag, "_filt_in1"}, filt_in[1], '0);
      check({tag, "_direct1"},  direct[1],  '0);
      check({tag, "_stb"}, OUT_BITS'(mix_stb), '0);
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      cycle     = '0;
      dca       = '0;
      filt      = '0;
      voice3off = '0;
`ifdef SID_MIXER_MUTE_EN
      mute      = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      smp = '{1000, 2000, 3000, -100, -200, -300};
      run_frame(6'b000000, 6'b000000, 2'b00, 6'd0, -1, 1'b1, 0, 6000, 0, -600);
      run_frame(6'b100010, 6'b100010, 2'b00, 6'd0, -1, 1'b1, 2000, 4000, -300, -300);
      run_frame(6'b000100, 6'b000100, 2'b11, 6'd0, -1, 1'b1, 3000, 3000, 0, -300);
      // routing change between chip 0 and chip 1 slots
      run_frame(6'b000000, 6'b111111, 2'b00, 6'd0, -1, 1'b1, 0, 6000, -600, 0);

      smp = '{-2097152, -2097152, -2097152, -2097152, -2097152, -2097152};
      run_frame(6'b000000, 6'b000000, 2'b00, 6'd0, -1, 1'b1, 0, -6291456, 0, -6291456);

      smp = '{1000, 2000, 3000, -100, -200, -300};
      run_frame(6'b000000, 6'b000000, 2'b00, 6'd0, FIRST_SLOT + 2, 1'b0, 0, 0, 0, 0);
      check_zero("mid_reset");
      run_frame(6'b000000, 6'b000000, 2'b00, 6'd0, -1, 1'b1, 0, 6000, 0, -600);
      run_frame(6'b100010, 6'b100010, 2'b00, 6'd0, FIRST_SLOT + 5, 1'b0, 0, 0, 0, 0);
      check_zero("pub_reset");
      run_frame(6'b100010, 6'b100010, 2'b00, 6'd0, -1, 1'b1, 2000, 4000, -300, -300);

`ifdef SID_MIXER_MUTE_EN
      smp = '{500, 500, 500, 0, 0, 0};
      run_frame(6'b000000, 6'b000000, 2'b00, 6'b000001, -1, 1'b1, 0, 1000, 0, 0);
`endif

      repeat (4) @(posedge clk);
      #1;
      check("pending_frames", OUT_BITS'(exp_q.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sid_voice_mixer.md
# sid_voice_mixer

Consumer of the time-multiplexed voice DCA output stream. Captures the six signed voice samples (two SID chips × three voices) on their cycle slots, routes each voice to either the filter input sum or the direct (filter bypass) sum of its chip, and presents four registered per-chip sums with a one-clock strobe. Sits between the voice DCA and the filter/output stage.

## Interface
Parameters:
- FIRST_SLOT, 8, cycle on which voice 0 DCA output is valid; voices 1–5 follow on consecutive cycles.
- OUT_BITS, 24, width of each output sum (3 × s22 fits in s24).

Ports:
- clk  input  1  system clock; one clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- cycle  input  sid::cycle_t  global cycle index; wraps at end of sample period.
- dca  input  sid::s22_t  voice DCA output; voice n valid when cycle == FIRST_SLOT+n.
- filt  input  6  per-voice filter routing, bit n = voice n (0–2 chip 0, 3–5 chip 1); 1 = to filter.
- voice3off  input  2  per-chip voice 3 disconnect (bit 0 chip 0, bit 1 chip 1).
- mute  input  6  per-voice mute (present only with SID_MIXER_MUTE_EN).
- filt_in  output  2×OUT_BITS signed  per-chip filter input sum.
- direct  output  2×OUT_BITS signed  per-chip bypass sum.
- mix_stb  output  1  high for one clock when all four sums are updated.

## Operation
- Slot index s = cycle − FIRST_SLOT; active when 0 ≤ s ≤ 5. chip = s/3, voice-in-chip v = s%3.
- filt, voice3off, mute sampled on the same clock as the dca sample of the slot.
- Per slot: sample is sign-extended to OUT_BITS and added to exactly one accumulator of its chip:
  - filt[s]=1 → filter accumulator.
  - filt[s]=0, v==2, voice3off[chip]=1 → dropped (neither sum).
  - otherwise → direct accumulator.
  - Muted voice (macro enabled) → dropped regardless of routing.
- First slot of each chip (s=0, s=3) loads accumulators (routed value or 0) instead of adding; no explicit clear needed.
- Frame flag: set on slot 0, cleared by rst. Only frames whose flag is set at slot 5 are published.
- Publish: on the edge ending slot 5, final accumulated values copied to filt_in/direct; mix_stb registered high for the following clock only.
- Arithmetic: two's complement, no saturation required; max |sum| < 2^23.
- Outputs hold between publishes.

## Timing
- Capture latency: dca on cycle FIRST_SLOT+n is registered on the edge ending that cycle.
- Output latency: outputs and mix_stb valid during cycle FIRST_SLOT+6 (1 clock after last slot).
- Reset values: filt_in = 0, direct = 0, mix_stb = 0, accumulators = 0, frame flag = 0.
- Reset mid-frame: partial frame discarded; no mix_stb for that frame even if rst deasserts before slot 5; next full frame publishes normally.
- rst asserted on the publish edge: reset wins; outputs stay 0, mix_stb 0.
- Routing inputs changing mid-frame affect only slots sampled after the change.
- cycle wrap: no state depends on cycles outside slots 0–5 except the held outputs.

## Configuration
- SID_MIXER_MUTE_EN defined: mute port present; muted voices contribute 0 to both sums.
- Undefined: no mute port; all voices routed per filt/voice3off only.

## Test plan
- Voices 0–5 = 1000, 2000, 3000, −100, −200, −300, filt=0, voice3off=0 → direct = {6000, −600}, filt_in = {0,0}, mix_stb one clock at cycle FIRST_SLOT+6.
- Same samples, filt=6'b100010 → chip0 filt_in=2000 direct=4000; chip1 filt_in=−300 direct=−300.
- voice3off=2'b11, filt=6'b000100 → chip0 voice 3 (3000) still in filt_in; chip1 voice 3 (−300) dropped: direct chip1 = −300.
- All voices = −2^21 → direct = {−3·2^21, −3·2^21}, no overflow, sign correct.
- rst pulsed during slot 2, released at slot 3 → no mix_stb that frame, outputs 0; next frame publishes correct sums.
- With SID_MIXER_MUTE_EN, mute=6'b000001, voices 0–2 = 500 → direct chip0 = 1000.
